// File: rtl/b8b10_pkg.sv
// Shared types, comma patterns and the 8b10b running-weight check used by the
// word aligner.
package b8b10_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    SYNC    = 2'd2
  } align_state_t;

  localparam logic [6:0] COMMA_NEG = 7'b0011111;
  localparam logic [6:0] COMMA_POS = 7'b1100000;

  function automatic logic [3:0] popcount10(input logic [9:0] w);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 10; i++) begin
      c = c + {3'b000, w[i]};
    end
    return c;
  endfunction

  // Legal 8b10b codes keep the whole word and both sub-blocks near DC balance.
  function automatic logic sym_weight_ok(input logic [9:0] w);
    logic [3:0] all_n;
    logic [3:0] six_n;
    logic [3:0] four_n;
    all_n  = popcount10(w);
    six_n  = popcount10({4'b0000, w[9:4]});
    four_n = popcount10({6'b000000, w[3:0]});
    return (all_n >= 4'd4) && (all_n <= 4'd6) &&
           (six_n >= 4'd2) && (six_n <= 4'd4) &&
           (four_n >= 4'd1) && (four_n <= 4'd3);
  endfunction

endpackage

// File: rtl/b10_word_align_if.sv
// Serial-in / symbol-out bundle of the word aligner.
interface b10_word_align_if;
  logic       rx_bit;
  logic       rx_bit_valid;
  logic       realign;
  logic [9:0] sym;
  logic [3:0] fghj;
  logic       sym_valid;
  logic       sym_is_comma;
  logic       sym_err;
  logic       locked;

  modport master (
    output rx_bit, rx_bit_valid, realign,
    input  sym, fghj, sym_valid, sym_is_comma, sym_err, locked
  );

  modport slave (
    input  rx_bit, rx_bit_valid, realign,
    output sym, fghj, sym_valid, sym_is_comma, sym_err, locked
  );
endinterface

// File: rtl/b10_sym_check.sv
// Combinational classifier for the current 10-bit window: comma and weight error.
module b10_sym_check
  import b8b10_pkg::*;
(
  input  logic [9:0] win,
  output logic       is_comma,
  output logic       is_err
);

  assign is_comma = (win[9:3] == COMMA_NEG) || (win[9:3] == COMMA_POS);
  assign is_err   = !sym_weight_ok(win);

endmodule

// File: rtl/b10_word_align.sv
// 8b10b symbol aligner: comma-based boundary search with hunt/confirm/sync lock.
module b10_word_align
  import b8b10_pkg::*;
#(
  parameter int COMMA_CONFIRM = 3,
  parameter int LOSS_ERRS     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  b10_word_align_if.slave  bus
);

  localparam int CW = $clog2(COMMA_CONFIRM + 1);
  localparam int EW = $clog2(LOSS_ERRS + 1);
  localparam logic [CW-1:0] CC_LAST = CW'(COMMA_CONFIRM);
  localparam logic [EW-1:0] EC_LAST = EW'(LOSS_ERRS);

  // Only nine history bits are needed; the tenth comes straight from the line.
  logic [8:0]    sh;
  logic [8:0]    sh_n;
  logic [9:0]    win;
  logic [3:0]    bit_cnt;
  logic [3:0]    bit_cnt_n;
  logic [CW-1:0] ccnt;
  logic [CW-1:0] ccnt_n;
  logic [EW-1:0] ecnt;
  logic [EW-1:0] ecnt_n;
  align_state_t  state;
  align_state_t  state_n;
  logic          boundary;
  logic          emit;
  logic          is_comma;
  logic          is_err;

  assign win      = {sh, bus.rx_bit};
  assign boundary = bus.rx_bit_valid && (bit_cnt == 4'd9);

  b10_sym_check u_check (
    .win      (win),
    .is_comma (is_comma),
    .is_err   (is_err)
  );

  // Next-state, counter and emit decisions for the current bit.
  always_comb begin
    state_n   = state;
    ccnt_n    = ccnt;
    ecnt_n    = ecnt;
    emit      = 1'b0;
    if (bus.rx_bit_valid) begin
      sh_n      = win[8:0];
      bit_cnt_n = boundary ? 4'd0 : bit_cnt + 4'd1;
    end else begin
      sh_n      = sh;
      bit_cnt_n = bit_cnt;
    end

    if (bus.realign) begin
      state_n   = HUNT;
      ccnt_n    = '0;
      ecnt_n    = '0;
      bit_cnt_n = 4'd0;
    end else if (bus.rx_bit_valid) begin
      case (state)
        HUNT: begin
          if (is_comma) begin
            emit      = 1'b1;
            bit_cnt_n = 4'd0;
            ccnt_n    = CW'(1);
            ecnt_n    = '0;
            state_n   = (COMMA_CONFIRM == 1) ? SYNC : CONFIRM;
          end else begin
            state_n = HUNT;
          end
        end
        CONFIRM: begin
          if (boundary) begin
            emit = 1'b1;
            if (is_comma) begin
              if (ccnt >= CC_LAST - CW'(1)) begin
                ccnt_n  = CC_LAST;
                ecnt_n  = '0;
                state_n = SYNC;
              end else begin
                ccnt_n = ccnt + CW'(1);
              end
            end else if (is_err) begin
              state_n = HUNT;
            end else begin
              state_n = CONFIRM;
            end
          end else if (is_comma) begin
            // Comma at an unexpected phase: restart confirmation from here.
            emit      = 1'b1;
            bit_cnt_n = 4'd0;
            ccnt_n    = CW'(1);
          end else begin
            state_n = CONFIRM;
          end
        end
        SYNC: begin
          if (boundary) begin
            emit = 1'b1;
            if (is_err) begin
              if (ecnt >= EC_LAST - EW'(1)) begin
                ecnt_n  = EC_LAST;
                state_n = HUNT;
              end else begin
                ecnt_n = ecnt + EW'(1);
              end
            end else begin
              ecnt_n = '0;
            end
          end else begin
            state_n = SYNC;
          end
        end
        default: begin
          state_n = HUNT;
        end
      endcase
    end else begin
      state_n = state;
    end
  end

  // State, counters and registered symbol outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= HUNT;
      sh               <= 9'd0;
      bit_cnt          <= 4'd0;
      ccnt             <= '0;
      ecnt             <= '0;
      bus.sym          <= 10'd0;
      bus.fghj         <= 4'd0;
      bus.sym_valid    <= 1'b0;
      bus.sym_is_comma <= 1'b0;
      bus.sym_err      <= 1'b0;
      bus.locked       <= 1'b0;
    end else begin
      state         <= state_n;
      sh            <= sh_n;
      bit_cnt       <= bit_cnt_n;
      ccnt          <= ccnt_n;
      ecnt          <= ecnt_n;
      bus.sym_valid <= emit;
      bus.locked    <= (state_n == SYNC);
      if (emit) begin
        bus.sym          <= win;
        bus.fghj         <= win[3:0];
        bus.sym_is_comma <= is_comma;
        bus.sym_err      <= is_err;
      end
    end
  end

endmodule

// File: tb/tb_b10_word_align.sv
// Bench for b10_word_align: directed acquire/loss/re-phase/gap/realign cases and
// a randomized symbol stream, all checked cycle by cycle against a stream model.
module tb_b10_word_align;

  localparam int CONF = 3;
  localparam int LOSS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  b10_word_align_if bus ();

  b10_word_align #(.COMMA_CONFIRM(CONF), .LOSS_ERRS(LOSS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- behavioural model ----------------
  bit         hist[$];
  int         m_mode;   // 0 hunting, 1 confirming, 2 locked
  int         m_since;
  int         m_cc;
  int         m_ec;
  logic [9:0] e_sym;
  logic       e_valid, e_comma, e_err, e_locked;

  function automatic int ones(input logic [9:0] w, input int hi, input int lo);
    int n = 0;
    for (int i = lo; i <= hi; i++) n += int'(w[i]);
    return n;
  endfunction

  function automatic bit legal(input logic [9:0] w);
    int t = ones(w, 9, 0);
    int s = ones(w, 9, 4);
    int f = ones(w, 3, 0);
    return (t >= 4 && t <= 6) && (s >= 2 && s <= 4) && (f >= 1 && f <= 3);
  endfunction

  function automatic bit comma(input logic [9:0] w);
    return (w[9:3] == 7'b0011111) || (w[9:3] == 7'b1100000);
  endfunction

  function automatic logic [9:0] window();
    logic [9:0] w;
    for (int i = 0; i < 10; i++) w[9-i] = hist[i];
    return w;
  endfunction

  task automatic m_emit(input logic [9:0] w);
    e_valid = 1'b1;
    e_sym   = w;
    e_comma = comma(w);
    e_err   = !legal(w);
  endtask

  initial begin
    hist = {};
    repeat (10) hist.push_back(1'b0);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        hist = {};
        repeat (10) hist.push_back(1'b0);
        m_mode = 0; m_since = 0; m_cc = 0; m_ec = 0;
        e_sym = 10'd0; e_valid = 1'b0; e_comma = 1'b0; e_err = 1'b0; e_locked = 1'b0;
      end else begin
        logic [9:0] w;
        bit at_b;
        e_valid = 1'b0;
        at_b = bus.rx_bit_valid && (m_since == 9);
        if (bus.rx_bit_valid) begin
          hist.push_back(bus.rx_bit);
          void'(hist.pop_front());
          m_since = at_b ? 0 : m_since + 1;
        end
        w = window();
        if (bus.realign) begin
          m_mode = 0; m_since = 0; m_cc = 0; m_ec = 0;
        end else if (bus.rx_bit_valid) begin
          if (m_mode == 0) begin
            if (comma(w)) begin
              m_emit(w);
              m_since = 0; m_cc = 1; m_ec = 0;
              m_mode = (CONF == 1) ? 2 : 1;
            end
          end else if (m_mode == 1) begin
            if (at_b) begin
              m_emit(w);
              if (comma(w)) begin
                m_cc++;
                if (m_cc >= CONF) begin m_mode = 2; m_ec = 0; end
              end else if (!legal(w)) begin
                m_mode = 0;
              end
            end else if (comma(w)) begin
              m_emit(w);
              m_since = 0; m_cc = 1;
            end
          end else begin
            if (at_b) begin
              m_emit(w);
              if (!legal(w)) begin
                m_ec++;
                if (m_ec >= LOSS) m_mode = 0;
              end else begin
                m_ec = 0;
              end
            end
          end
        end
        e_locked = (m_mode == 2);
      end
    end
  end

  // Every cycle out of reset, all outputs must equal the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checks++;
        if ({bus.sym, bus.fghj, bus.sym_valid, bus.sym_is_comma, bus.sym_err, bus.locked} !==
            {e_sym, e_sym[3:0], e_valid, e_comma, e_err, e_locked}) begin
          errors++;
          $display("FAIL cycle_compare t=%0t: actual sym=%b fghj=%b v=%b c=%b e=%b l=%b required sym=%b fghj=%b v=%b c=%b e=%b l=%b",
                   $time, bus.sym, bus.fghj, bus.sym_valid, bus.sym_is_comma, bus.sym_err, bus.locked,
                   e_sym, e_sym[3:0], e_valid, e_comma, e_err, e_locked);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [9:0] k5n, k5p, k7n, d215, d102, d00n, d00p, bad;
  logic [9:0] pool [0:7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send_bit(input logic b, input logic v, input logic ra);
    @(negedge clk);
    bus.rx_bit       = b;
    bus.rx_bit_valid = v;
    bus.realign      = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [9:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(w[i], 1'b1, 1'b0);
  endtask

  task automatic send_word(input logic [9:0] w);
    send_bits(w, 9, 0);
  endtask

  task automatic random_stream(input int n_words);
    for (int n = 0; n < n_words; n++) begin
      logic [9:0] w;
      w = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 15) == 0) send_bit(1'($urandom_range(0, 1)), 1'b1, 1'b0);
      for (int i = 9; i >= 0; i--) begin
        while ($urandom_range(0, 4) == 0)
          send_bit(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 299) == 0));
        send_bit(w[i], 1'b1, 1'($urandom_range(0, 299) == 0));
      end
    end
    send_bit(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    k5n = 10'b0011111010; k5p = 10'b1100000101; k7n = 10'b0011111000;
    d215 = 10'b1010101010; d102 = 10'b0101010101;
    d00n = 10'b1001110100; d00p = 10'b0110001011; bad = 10'b1111111111;
    pool[0] = k5n; pool[1] = k5p; pool[2] = k7n; pool[3] = d215;
    pool[4] = d102; pool[5] = d00n; pool[6] = d00p; pool[7] = bad;
    bus.rx_bit = 1'b0; bus.rx_bit_valid = 1'b0; bus.realign = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_outputs", 32'({bus.sym, bus.fghj, bus.sym_valid, bus.sym_is_comma, bus.sym_err}), 32'd0);
    chk("reset_locked", 32'(bus.locked), 32'd0);

    // Acquire
    send_bit(1'b0, 1'b1, 1'b0); send_bit(1'b1, 1'b1, 1'b0); send_bit(1'b0, 1'b1, 1'b0);
    send_word(k5n);
    chk("acq1_valid", 32'(bus.sym_valid), 32'd1);
    chk("acq1_sym", 32'(bus.sym), 32'(10'b0011111010));
    chk("acq1_fghj", 32'(bus.fghj), 32'(4'b1010));
    chk("acq1_comma", 32'(bus.sym_is_comma), 32'd1);
    send_word(d215);
    chk("acq2_valid", 32'(bus.sym_valid), 32'd1);
    chk("acq2_comma", 32'(bus.sym_is_comma), 32'd0);
    send_word(k5p);
    send_word(d215);
    chk("acq4_locked", 32'(bus.locked), 32'd0);
    send_word(k5n);
    chk("acq5_valid", 32'(bus.sym_valid), 32'd1);
    chk("acq5_locked", 32'(bus.locked), 32'd1);

    // Loss of lock
    for (int i = 0; i < 3; i++) begin
      send_word(bad);
      chk("loss_a_err", 32'(bus.sym_err), 32'd1);
      chk("loss_a_locked", 32'(bus.locked), 32'd1);
    end
    send_word(d215);
    chk("loss_good_err", 32'(bus.sym_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      send_word(bad);
      chk("loss_b_locked", 32'(bus.locked), (i == 3) ? 32'd0 : 32'd1);
    end

    // Re-phase inside CONFIRM
    send_word(k5n);
    chk("rph_hunt_comma", 32'({bus.sym_valid, bus.sym_is_comma, bus.locked}), 32'(3'b110));
    send_word(d215);
    send_bit(1'b1, 1'b1, 1'b0);
    send_bits(k5p, 9, 1);
    chk("rph_old_phase_sym", 32'({bus.sym_valid, bus.sym, bus.sym_err}), 32'({1'b1, 10'b1110000010, 1'b0}));
    send_bit(k5p[0], 1'b1, 1'b0);
    chk("rph_new_comma", 32'({bus.sym_valid, bus.sym_is_comma, bus.sym}), 32'({2'b11, 10'b1100000101}));
    send_word(d215);
    send_word(k5n);
    chk("rph_locked_after1", 32'(bus.locked), 32'd0);
    send_word(d215);
    send_word(k5p);
    chk("rph_locked_after2", 32'(bus.locked), 32'd1);

    // Gap mid-symbol in SYNC
    send_bits(d102, 9, 6);
    repeat (7) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    send_bits(d102, 5, 0);
    chk("gap_sym", 32'({bus.sym_valid, bus.sym, bus.locked}), 32'({1'b1, 10'b0101010101, 1'b1}));

    // Realign on a boundary bit
    send_bits(d215, 9, 1);
    send_bit(d215[0], 1'b1, 1'b1);
    chk("realign_no_valid", 32'(bus.sym_valid), 32'd0);
    chk("realign_unlocked", 32'(bus.locked), 32'd0);
    send_word(k5n); send_word(d215); send_word(k5p); send_word(d215);
    chk("relock_before", 32'(bus.locked), 32'd0);
    send_word(k5n);
    chk("relock_after", 32'(bus.locked), 32'd1);

    random_stream(1200);

    // Asynchronous reset between clock edges
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs",
        32'({bus.sym, bus.fghj, bus.sym_valid, bus.sym_is_comma, bus.sym_err, bus.locked}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_word(k5p);
    chk("post_rst_hunt", 32'({bus.sym_valid, bus.sym_is_comma, bus.locked}), 32'(3'b110));

    random_stream(1200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
